aer_decoder: RTL

//  Receive side of the address-event link: accepts packed 39-bit AER words from the aer packer and buffers them in a small FIFO.

---
 rtl/aer_pkg.sv | 25 ++
 rtl/aer_fifo.sv | 65 ++++++
 rtl/aer_decoder.sv | 119 +++++++++++
 3 files changed

// File: rtl/aer_pkg.sv
// Shared AER word layout. The packer and the decoder both import this package.
package aer_pkg;
  localparam int AER_W      = 39;
  localparam int AER_ADDR_W = 3;
  localparam int AER_TS_W   = 32;

  localparam int POL_BIT = 0;
  localparam int TS_LSB  = 1;
  localparam int TS_MSB  = 32;
  localparam int Y_LSB   = 33;
  localparam int Y_MSB   = 35;
  localparam int X_LSB   = 36;
  localparam int X_MSB   = 38;

  typedef struct packed {
    logic [AER_ADDR_W-1:0] x;
    logic [AER_ADDR_W-1:0] y;
    logic [AER_TS_W-1:0]   ts;
    logic                  pol;
  } aer_event_t;

  function automatic aer_event_t aer_unpack(logic [AER_W-1:0] word);
    return aer_event_t'(word);
  endfunction
endpackage

// File: rtl/aer_fifo.sv
// Show-ahead synchronous FIFO. Full and empty are flops derived from the
// next occupancy, so neither flag depends combinationally on push or pop.
module aer_fifo #(
  parameter int W     = 39,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          full_q, full_d, empty_q, empty_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic          push_ok, pop_ok;

  assign push_ok = push_i & ~full_q;
  assign pop_ok  = pop_i & ~empty_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wdata_i;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) rd_ptr_d = rd_ptr_q + 1'b1;
    cnt_d   = cnt_q + CW'(push_ok) - CW'(pop_ok);
    full_d  = (cnt_d == CW'(DEPTH));
    empty_d = (cnt_d == '0);
  end

  // Storage is reset too so the decoded head reads zero, never X, after reset.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      mem_q    <= mem_d;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
endmodule

// File: rtl/aer_decoder.sv
// AER receive side: buffers packed words, decodes the head entry, checks
// timestamp monotonicity at push and counts delivered events per polarity.
module aer_decoder
  import aer_pkg::*;
#(
  parameter int ADDR_W   = AER_ADDR_W,
  parameter int TS_W     = AER_TS_W,
  parameter int DEPTH    = 4,
  parameter int CNT_W    = 16,
  parameter int WRAP_WIN = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              aer_valid_i,
  input  logic [AER_W-1:0]  aer_data_i,
  output logic              aer_ready_o,
  output logic              evt_valid_o,
  input  logic              evt_ready_i,
  output logic [ADDR_W-1:0] x_add_o,
  output logic [ADDR_W-1:0] y_add_o,
  output logic [TS_W-1:0]   timestamp_o,
  output logic              polarity_o,
  input  logic              clear_i,
  output logic              ts_err_o,
  output logic [CNT_W-1:0]  err_cnt_o,
  output logic [CNT_W-1:0]  pos_cnt_o,
  output logic [CNT_W-1:0]  neg_cnt_o
);
  localparam logic [TS_W:0] WRAP_LO = {1'b1, {TS_W{1'b0}}} - (TS_W+1)'(WRAP_WIN);

  logic [AER_W-1:0] head_word;
  logic             fifo_full, fifo_empty;
  logic             push, pop;
  aer_event_t       in_evt, head_evt;

  logic [TS_W-1:0]  last_ts_q, last_ts_d;
  logic             have_last_q, have_last_d;
  logic             ts_err_q, ts_err_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d, pos_cnt_q, pos_cnt_d, neg_cnt_q, neg_cnt_d;
  logic             ts_ok, err_hit;

  assign push = aer_valid_i & ~fifo_full;
  assign pop  = ~fifo_empty & evt_ready_i;

  aer_fifo #(.W(AER_W), .DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (push),
    .wdata_i (aer_data_i),
    .pop_i   (pop),
    .rdata_o (head_word),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign in_evt   = aer_unpack(aer_data_i);
  assign head_evt = aer_unpack(head_word);

  // A small timestamp right after one near the top of the range is a wrap, not a reorder.
  assign ts_ok   = (in_evt.ts >= last_ts_q) |
                   (({1'b0, last_ts_q} >= WRAP_LO) & (in_evt.ts < TS_W'(WRAP_WIN)));
  assign err_hit = push & have_last_q & ~ts_ok;

  always_comb begin
    last_ts_d   = last_ts_q;
    have_last_d = have_last_q;
    ts_err_d    = ts_err_q;
    err_cnt_d   = err_cnt_q;
    pos_cnt_d   = pos_cnt_q;
    neg_cnt_d   = neg_cnt_q;
    if (push) begin
      last_ts_d   = in_evt.ts;
      have_last_d = 1'b1;
    end
    if (clear_i) begin
      have_last_d = 1'b0;
      ts_err_d    = 1'b0;
      err_cnt_d   = '0;
      pos_cnt_d   = '0;
      neg_cnt_d   = '0;
    end else begin
      if (err_hit) begin
        ts_err_d = 1'b1;
        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
      end
      if (pop && head_evt.pol && pos_cnt_q != '1) pos_cnt_d = pos_cnt_q + 1'b1;
      if (pop && !head_evt.pol && neg_cnt_q != '1) neg_cnt_d = neg_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      last_ts_q   <= '0;
      have_last_q <= 1'b0;
      ts_err_q    <= 1'b0;
      err_cnt_q   <= '0;
      pos_cnt_q   <= '0;
      neg_cnt_q   <= '0;
    end else begin
      last_ts_q   <= last_ts_d;
      have_last_q <= have_last_d;
      ts_err_q    <= ts_err_d;
      err_cnt_q   <= err_cnt_d;
      pos_cnt_q   <= pos_cnt_d;
      neg_cnt_q   <= neg_cnt_d;
    end
  end

  assign aer_ready_o = ~fifo_full;
  assign evt_valid_o = ~fifo_empty;
  assign x_add_o     = head_evt.x;
  assign y_add_o     = head_evt.y;
  assign timestamp_o = head_evt.ts;
  assign polarity_o  = head_evt.pol;
  assign ts_err_o    = ts_err_q;
  assign err_cnt_o   = err_cnt_q;
  assign pos_cnt_o   = pos_cnt_q;
  assign neg_cnt_o   = neg_cnt_q;
endmodule
